// File: rtl/ex_muldiv.sv
// Iterative RV M-extension unit beside the EX ALU: shift-add multiply (MUL_STEP bits/cycle), restoring divide (1 bit/cycle).
// Raises stallreq until the result is ready, holds it until ex_adv; flush or rst cancels any op in flight.
module ex_muldiv #(
  parameter int XLEN     = 64,
  parameter int MUL_STEP = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [2:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic            ex_adv,
  input  logic            flush,
  output logic            busy,
  output logic            stallreq,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result
);
  localparam int CW     = $clog2(XLEN + 1);
  localparam int MULW_N = (MUL_STEP >= 32) ? 1 : 32 / MUL_STEP;
  localparam logic [CW-1:0] MUL_LAST  = CW'(XLEN / MUL_STEP - 1);
  localparam logic [CW-1:0] MULW_LAST = CW'(MULW_N - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(XLEN - 1);
  localparam logic [CW-1:0] DIVW_LAST = CW'(31);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t state, state_nx;

  logic [2:0]          op_q;
  logic                word_q, neg1_q, neg2_q;
  logic [CW-1:0]       cnt;
  logic [2*XLEN-1:0]   mcand, acc;
  logic [XLEN-1:0]     sreg, dvsr, rem, res;

  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sgn);
    logic [XLEN-1:0] r;
    r = XLEN'(v[31:0]);
    if (sgn) r = XLEN'($signed(v[31:0]));
    return r;
  endfunction

  // Operand decode for the op being accepted this cycle
  logic            word, sgn1, sgn2, neg1, neg2, dz, ovf;
  logic [XLEN-1:0] x1, x2, m1, m2, min_v, spec_res;
  always_comb begin
    word     = in_word && (XLEN == 64);
    sgn1     = in_op[2] ? ~in_op[0] : (in_op != 3'd3);
    sgn2     = in_op[2] ? ~in_op[0] : ~in_op[1];
    x1       = word ? ext32(in_src1, sgn1) : in_src1;
    x2       = word ? ext32(in_src2, sgn2) : in_src2;
    neg1     = sgn1 & x1[XLEN-1];
    neg2     = sgn2 & x2[XLEN-1];
    m1       = neg1 ? -x1 : x1;
    m2       = neg2 ? -x2 : x2;
    min_v    = word ? ext32(XLEN'(32'h8000_0000), 1'b1) : (XLEN'(1) << (XLEN - 1));
    dz       = (x2 == '0);
    ovf      = sgn1 && (x1 == min_v) && (x2 == '1);
    spec_res = in_op[1] ? (dz ? x1 : '0) : (dz ? '1 : x1);
  end

  // One iteration of each datapath, with sign fix-up for the final step
  logic [2*XLEN-1:0] partial, acc_nx, prod;
  logic [XLEN:0]     rsh;
  logic [XLEN-1:0]   rem_nx, quo_nx, quo_f, rem_f, mul_res, div_res;
  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_STEP; i++)
      if (sreg[i]) partial = partial + (mcand << i);
    acc_nx  = acc + partial;
    prod    = (neg1_q ^ neg2_q) ? -acc_nx : acc_nx;
    mul_res = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    if (word_q) mul_res = ext32(mul_res, 1'b1);

    rsh = {rem, sreg[XLEN-1]};
    if (rsh >= {1'b0, dvsr}) begin
      rem_nx = XLEN'(rsh - {1'b0, dvsr});
      quo_nx = {sreg[XLEN-2:0], 1'b1};
    end else begin
      rem_nx = rsh[XLEN-1:0];
      quo_nx = {sreg[XLEN-2:0], 1'b0};
    end
    quo_f   = (neg1_q ^ neg2_q) ? -quo_nx : quo_nx;
    rem_f   = neg1_q ? -rem_nx : rem_nx;
    div_res = op_q[1] ? rem_f : quo_f;
    if (word_q) div_res = ext32(div_res, 1'b1);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:       if (in_valid) state_nx = !in_op[2] ? S_MUL : (dz || ovf) ? S_DONE : S_DIV;
      S_MUL, S_DIV: if (cnt == '0) state_nx = S_DONE;
      S_DONE:       if (ex_adv) state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= '0;
      word_q <= 1'b0;
      neg1_q <= 1'b0;
      neg2_q <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      sreg   <= '0;
      dvsr   <= '0;
      rem    <= '0;
      res    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (in_valid && !flush) begin
          op_q   <= in_op;
          word_q <= word;
          neg1_q <= neg1;
          neg2_q <= neg2;
          mcand  <= (2*XLEN)'(m1);
          acc    <= '0;
          dvsr   <= m2;
          rem    <= '0;
          res    <= word ? ext32(spec_res, 1'b1) : spec_res;
          // Divide walks the dividend from its MSB, so a W dividend is pre-aligned to the top
          if (in_op[2]) begin
            sreg <= word ? (m1 << 32) : m1;
            cnt  <= word ? DIVW_LAST : DIV_LAST;
          end else begin
            sreg <= m2;
            cnt  <= word ? MULW_LAST : MUL_LAST;
          end
        end
        S_MUL: begin
          acc   <= acc_nx;
          mcand <= mcand << MUL_STEP;
          sreg  <= sreg >> MUL_STEP;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) res <= mul_res;
        end
        S_DIV: begin
          sreg <= quo_nx;
          rem  <= rem_nx;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) res <= div_res;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign out_valid  = (state == S_DONE);
  assign out_result = out_valid ? res : '0;
  assign stallreq   = in_valid & ~out_valid;

  a_hold_valid: assert property (@(posedge clk) disable iff (rst)
    ((state == S_MUL || state == S_DIV) && !flush) |-> in_valid);
endmodule
